led_fader: RTL and testbench

//  Downstream of the blinken animator: consumes its raw N-bit LED pattern and drives the board LEDs.

---
 rtl/led_fader_pkg.sv | 19 +
 rtl/led_fader_channel.sv | 104 ++++++++++
 rtl/led_fader.sv | 103 ++++++++++
 tb/tb_led_fader.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/led_fader_pkg.sv
// Package for the LED fader slice.
// Holds the default channel count and PWM resolution shared with the
// blinken animator, the default ramp divider, and the per-channel ramp
// direction type.
package led_fader_pkg;

  localparam int LED_COUNT    = 8;
  localparam int LED_PWM_BITS = 8;
  localparam int LED_RAMP_DIV = 256;

  // Direction a channel's brightness level takes on the current clock
  typedef enum logic [1:0] {
    DIR_HOLD = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2,
    DIR_SNAP = 2'd3
  } ramp_dir_t;

endpackage

// File: rtl/led_fader_channel.sv
// One LED channel of the fader.
// Holds the brightness level, the level-to-duty mapping, the duty register
// that is reloaded only at PWM frame boundaries, and the PWM compare that
// produces the registered LED drive.
// GAMMA_EN selects the squared (gamma ~2) mapping instead of the linear one;
// the top level derives it from the LED_GAMMA_EN macro.
module led_fader_channel
  import led_fader_pkg::*;
#(
  parameter int PWM_BITS = LED_PWM_BITS,
  parameter bit GAMMA_EN = 1'b0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                target,
  input  logic                fade_en,
  input  logic                ramp_tick,
  input  logic                frame_start,
  input  logic [PWM_BITS-1:0] pwm_ctr,
  output logic [PWM_BITS-1:0] level,
  output logic                led
);

  localparam logic [PWM_BITS-1:0] MAX_LEVEL = '1;
  localparam logic [PWM_BITS-1:0] MIN_LIT   = PWM_BITS'(1);

  ramp_dir_t           dir;
  logic [PWM_BITS-1:0] mapped;
  logic [PWM_BITS-1:0] duty;

  // Decide how the level moves this clock: snap when fading is off,
  // otherwise one saturating step toward the target on each ramp tick
  always_comb begin
    dir = DIR_HOLD;
    if (!fade_en) begin
      dir = DIR_SNAP;
    end else if (ramp_tick) begin
      if (target && level != MAX_LEVEL) begin
        dir = DIR_UP;
      end else if (!target && level != '0) begin
        dir = DIR_DOWN;
      end
    end
  end

  // Brightness level; a target reversal simply flips the step direction
  // from wherever the level currently is, so it never jumps
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level <= '0;
    end else begin
      case (dir)
        DIR_SNAP: level <= target ? MAX_LEVEL : '0;
        DIR_UP:   level <= level + 1'b1;
        DIR_DOWN: level <= level - 1'b1;
        default:  level <= level;
      endcase
    end
  end

  generate
    if (GAMMA_EN) begin : g_gamma
      logic [2*PWM_BITS-1:0] level_wide;
      logic [PWM_BITS-1:0]   scaled;

      // Squared brightness curve; tiny nonzero levels stay visibly lit and
      // full scale stays solid on
      always_comb begin
        level_wide = {{PWM_BITS{1'b0}}, level};
        scaled     = PWM_BITS'((level_wide * level_wide) >> PWM_BITS);
        if (level == MAX_LEVEL) begin
          mapped = MAX_LEVEL;
        end else if (level != '0 && scaled == '0) begin
          mapped = MIN_LIT;
        end else begin
          mapped = scaled;
        end
      end
    end else begin : g_linear
      assign mapped = level;
    end
  endgenerate

  // Duty is only reloaded on the last clock of a frame so the lit width
  // never changes part way through a PWM period
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      duty <= '0;
    end else if (frame_start) begin
      duty <= mapped;
    end
  end

  // PWM compare; full-scale duty is forced solid so it never blinks off
  // for the one count where pwm_ctr equals MAX
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led <= 1'b0;
    end else begin
      led <= (duty == MAX_LEVEL) | (pwm_ctr < duty);
    end
  end

endmodule

// File: rtl/led_fader.sv
// LED fader: sits after the blinken animator and turns its raw on/off
// pattern into per-LED PWM drive that ramps smoothly between off and full
// brightness (or snaps when fade_en is low).
// Optional build macro: LED_GAMMA_EN selects the squared brightness curve;
// without it the level maps linearly to PWM duty and no multiplier exists.
module led_fader
  import led_fader_pkg::*;
#(
  parameter int N_LEDS   = LED_COUNT,
  parameter int PWM_BITS = LED_PWM_BITS,
  parameter int RAMP_DIV = LED_RAMP_DIV
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_LEDS-1:0] leds_in,
  input  logic              fade_en,
  output logic [N_LEDS-1:0] led_out,
  output logic              busy
);

  localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [RAMP_W-1:0]   RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
  localparam logic [PWM_BITS-1:0] MAX_LEVEL = '1;

`ifdef LED_GAMMA_EN
  localparam bit GAMMA_EN = 1'b1;
`else
  localparam bit GAMMA_EN = 1'b0;
`endif

  logic [N_LEDS-1:0]   in_q;
  logic [N_LEDS-1:0]   off_target;
  logic [PWM_BITS-1:0] pwm_ctr;
  logic [RAMP_W-1:0]   ramp_ctr;
  logic                ramp_tick;
  logic                frame_start;
  logic [PWM_BITS-1:0] level [N_LEDS];

  // Register the animator pattern once; every channel decision uses this copy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_q <= '0;
    end else begin
      in_q <= leds_in;
    end
  end

  // Free-running PWM frame counter shared by all channels
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pwm_ctr <= '0;
    end else begin
      pwm_ctr <= pwm_ctr + 1'b1;
    end
  end

  // Ramp prescaler; RAMP_DIV need not be a power of two
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ramp_ctr <= '0;
    end else if (ramp_ctr == RAMP_LAST) begin
      ramp_ctr <= '0;
    end else begin
      ramp_ctr <= ramp_ctr + 1'b1;
    end
  end

  assign ramp_tick   = (ramp_ctr == RAMP_LAST);
  assign frame_start = (pwm_ctr == MAX_LEVEL);

  generate
    for (genvar i = 0; i < N_LEDS; i++) begin : g_chan
      led_fader_channel #(
        .PWM_BITS (PWM_BITS),
        .GAMMA_EN (GAMMA_EN)
      ) u_chan (
        .clock       (clock),
        .reset       (reset),
        .target      (in_q[i]),
        .fade_en     (fade_en),
        .ramp_tick   (ramp_tick),
        .frame_start (frame_start),
        .pwm_ctr     (pwm_ctr),
        .level       (level[i]),
        .led         (led_out[i])
      );

      assign off_target[i] = (level[i] != (in_q[i] ? MAX_LEVEL : '0));
    end
  endgenerate

  // Busy while any channel is still away from its endpoint; in snap mode
  // the level lands on the endpoint one clock after in_q, so busy is held
  // low there instead of flagging that single-clock transit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
    end else begin
      busy <= fade_en & (|off_target);
    end
  end

endmodule

// File: tb/tb_led_fader.sv
// Self-checking bench for led_fader (N_LEDS=4, PWM_BITS=4, RAMP_DIV=4).
// A behavioural model tracks time since reset, saturating levels, duty per
// frame and the expected LED/busy outputs; directed scenarios and random
// pattern changes are compared against it every clock.
// Honours LED_GAMMA_EN in the model's brightness mapping.
module tb_led_fader;

  localparam int N_LEDS   = 4;
  localparam int PWM_BITS = 4;
  localparam int RAMP_DIV = 4;
  localparam int MAXV     = (1 << PWM_BITS) - 1;
  localparam int FRAME    = 1 << PWM_BITS;

  logic              clock;
  logic              reset;
  logic [N_LEDS-1:0] leds_in;
  logic              fade_en;
  logic [N_LEDS-1:0] led_out;
  logic              busy;

  int checks = 0;
  int errors = 0;

  int                m_level [N_LEDS];
  int                m_duty  [N_LEDS];
  logic [N_LEDS-1:0] m_inq;
  logic [N_LEDS-1:0] m_led;
  logic              m_busy;
  int                m_cyc;

  led_fader #(
    .N_LEDS   (N_LEDS),
    .PWM_BITS (PWM_BITS),
    .RAMP_DIV (RAMP_DIV)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .leds_in (leds_in),
    .fade_en (fade_en),
    .led_out (led_out),
    .busy    (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int map_level(input int l);
`ifdef LED_GAMMA_EN
    int sq;
    sq = (l * l) >> PWM_BITS;
    if (l == MAXV) return MAXV;
    if (l != 0 && sq == 0) return 1;
    return sq;
`else
    return l;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_LEDS; i++) begin
      m_level[i] = 0;
      m_duty[i]  = 0;
    end
    m_inq  = '0;
    m_led  = '0;
    m_busy = 1'b0;
    m_cyc  = 0;
  endtask

  // One clock of the model, using the inputs present at the edge
  task automatic model_edge();
    int   new_level [N_LEDS];
    int   pwm;
    int   endpoint;
    bit   tick;
    bit   any_off;
    pwm     = m_cyc % FRAME;
    tick    = (m_cyc % RAMP_DIV) == RAMP_DIV - 1;
    any_off = 1'b0;
    for (int i = 0; i < N_LEDS; i++) begin
      endpoint = m_inq[i] ? MAXV : 0;
      if (m_level[i] != endpoint) any_off = 1'b1;
      if (!fade_en) new_level[i] = endpoint;
      else if (tick && m_inq[i]) new_level[i] = (m_level[i] < MAXV) ? m_level[i] + 1 : MAXV;
      else if (tick) new_level[i] = (m_level[i] > 0) ? m_level[i] - 1 : 0;
      else new_level[i] = m_level[i];
      m_led[i] = (m_duty[i] == MAXV) || (pwm < m_duty[i]);
      if (pwm == MAXV) m_duty[i] = map_level(m_level[i]);
    end
    m_busy = fade_en && any_off;
    for (int i = 0; i < N_LEDS; i++) m_level[i] = new_level[i];
    m_inq = leds_in;
    m_cyc++;
  endtask

  task automatic applyStimulus(input logic [N_LEDS-1:0] pattern, input logic fade);
    leds_in = pattern;
    fade_en = fade;
  endtask

  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      model_edge();
      #1;
      checkOutput("led_out", {28'd0, led_out}, {28'd0, m_led});
      checkOutput("busy", {31'd0, busy}, {31'd0, m_busy});
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(4'b1111, 1'b1);
    model_reset();

    // Outputs held low throughout reset
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checkOutput("rst_led", {28'd0, led_out}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    end
    @(negedge clock);
    reset = 1'b0;
    model_reset();

    // busy rises within two clocks of release
    runCycles(2);
    checkOutput("busy_after_rst", {31'd0, busy}, 32'd1);

    // Full fade up on channel 0
    applyStimulus(4'b0000, 1'b0);
    runCycles(3);
    applyStimulus(4'b0001, 1'b1);
    runCycles(15 * RAMP_DIV + 6);
    checkOutput("fade_up_busy", {31'd0, busy}, 32'd0);
    runCycles(FRAME * 2 + 1);
    for (int k = 0; k < FRAME; k++) begin
      runCycles(1);
      checkOutput("solid_on", {28'd0, led_out}, 32'h1);
    end

    // Reversal at level 7 ramps back down one step per tick
    applyStimulus(4'b0000, 1'b0);
    runCycles(3);
    applyStimulus(4'b0001, 1'b1);
    for (int k = 0; k < 100 && m_level[0] != 7; k++) runCycles(1);
    applyStimulus(4'b0000, 1'b1);
    runCycles(7 * RAMP_DIV + 6);
    checkOutput("rev_busy", {31'd0, busy}, 32'd0);
    runCycles(FRAME * 2 + 2);
    checkOutput("rev_off", {28'd0, led_out}, 32'd0);

    // Snap mode: busy never rises, pattern solid after a frame
    applyStimulus(4'b1010, 1'b0);
    for (int k = 0; k < 3; k++) begin
      runCycles(1);
      checkOutput("snap_busy", {31'd0, busy}, 32'd0);
    end
    runCycles(FRAME * 2 + 2);
    for (int k = 0; k < FRAME; k++) begin
      runCycles(1);
      checkOutput("snap_solid", {28'd0, led_out}, 32'ha);
    end

    // Random pattern and mode changes
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 11) == 0)
        applyStimulus(4'($urandom), 1'($urandom_range(0, 4) != 0));
      runCycles(1);
    end

    // Asynchronous reset in the middle of a fade down
    applyStimulus(4'b1111, 1'b0);
    runCycles(FRAME * 2 + 8);
    applyStimulus(4'b0000, 1'b1);
    runCycles(14);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_led", {28'd0, led_out}, 32'd0);
    checkOutput("async_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 60; c++) begin
      if ($urandom_range(0, 7) == 0)
        applyStimulus(4'($urandom), 1'($urandom_range(0, 3) != 0));
      runCycles(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
